// File: rtl/gpio_sw_debounce.sv
// ============================================================================
// Module   : gpio_sw_debounce
// Purpose  : Synchronise, debounce and edge-detect slide switches; sticky
//            per-bit change flags with write-1-to-clear and an OR'd interrupt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_sw_debounce #(
    parameter int WIDTH          = 16,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SAMPLE_HZ      = 1000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [WIDTH-1:0] i_clr,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_changed,
    output logic             o_irq
);

    localparam int c_TICK_DIV = CLK_FREQ_HZ / SAMPLE_HZ;
    localparam int c_TCW      = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int c_CW       = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;

    localparam logic [c_TCW-1:0] c_TICK_LAST = c_TCW'(c_TICK_DIV - 1);
    localparam logic [c_CW-1:0]  c_CNT_LAST  = c_CW'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [c_TCW-1:0]            tick_cnt_q, tick_cnt_d;
    logic                        w_tick;
    logic [WIDTH-1:0][c_CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]            w_accept;
    logic [WIDTH-1:0]            sw_q, sw_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic [WIDTH-1:0]            changed_q, changed_d;

    assign w_tick = (tick_cnt_q == c_TICK_LAST);

    always_comb begin
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
        cnt_d      = cnt_q;
        w_accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_tick) begin
                // any sample agreeing with the current level restarts the run
                if (sync2_q[i] == sw_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == c_CNT_LAST) begin
                    w_accept[i] = 1'b1;
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        sw_d      = sw_q ^ w_accept;
        rise_d    = w_accept & sync2_q;
        fall_d    = w_accept & ~sync2_q;
        // a new event wins over a simultaneous clear
        changed_d = (changed_q & ~i_clr) | w_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            cnt_q      <= '0;
            sw_q       <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            changed_q  <= '0;
        end else begin
            sync1_q    <= i_sw;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            changed_q  <= changed_d;
        end
    end

    assign o_sw      = sw_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_changed = changed_q;
    assign o_irq     = |changed_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_sw_debounce.sv
// ============================================================================
// Module   : tb_gpio_sw_debounce
// Purpose  : Scoreboard bench for gpio_sw_debounce with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_sw_debounce;

    localparam int c_W    = 16;
    localparam int c_DIV  = 10;
    localparam int c_STAB = 4;

    logic             clk;
    logic             rst;
    logic [c_W-1:0]   i_sw;
    logic [c_W-1:0]   i_clr;
    logic [c_W-1:0]   o_sw, o_rise, o_fall, o_changed;
    logic             o_irq;

    gpio_sw_debounce #(
        .WIDTH          (c_W),
        .CLK_FREQ_HZ    (100),
        .SAMPLE_HZ      (10),
        .STABLE_SAMPLES (c_STAB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sw      (i_sw),
        .i_clr     (i_clr),
        .o_sw      (o_sw),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_changed (o_changed),
        .o_irq     (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_W-1:0] sw;
        logic [c_W-1:0] rise;
        logic [c_W-1:0] fall;
        logic [c_W-1:0] chg;
        logic           irq;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: input seen two edges late, a sample every
    // c_DIV-th edge since reset, level flips after c_STAB differing samples in a row.
    logic [c_W-1:0] m_hist [2];
    int             m_edges;
    int             m_run [c_W];
    logic [c_W-1:0] m_lvl, m_chg;

    always @(posedge clk) begin
        exp_t           e;
        logic [c_W-1:0] s, acc;
        if (rst) begin
            m_hist[0] = '0; m_hist[1] = '0;
            m_edges = 0; m_lvl = '0; m_chg = '0;
            for (int b = 0; b < c_W; b++) m_run[b] = 0;
            e = '0;
        end else begin
            s = m_hist[0];
            m_hist[0] = m_hist[1];
            m_hist[1] = i_sw;
            acc = '0;
            if ((m_edges % c_DIV) == c_DIV - 1) begin
                for (int b = 0; b < c_W; b++) begin
                    if (s[b] == m_lvl[b]) m_run[b] = 0;
                    else if (m_run[b] + 1 == c_STAB) begin
                        acc[b] = 1'b1;
                        m_run[b] = 0;
                    end else m_run[b] = m_run[b] + 1;
                end
            end
            m_edges++;
            m_lvl = m_lvl ^ acc;
            m_chg = (m_chg & ~i_clr) | acc;
            e.sw = m_lvl; e.rise = acc & s; e.fall = acc & ~s;
            e.chg = m_chg; e.irq = |m_chg;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_sw", 32'(o_sw), 32'(e.sw));
            chk("o_rise", 32'(o_rise), 32'(e.rise));
            chk("o_fall", 32'(o_fall), 32'(e.fall));
            chk("o_changed", 32'(o_changed), 32'(e.chg));
            chk("o_irq", 32'(o_irq), 32'(e.irq));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after an input change at a negedge: cycles until o_sw[b] rises.
    task automatic latency(input string name, input int b);
        int n = 0;
        while (!o_sw[b] && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= 33 && n <= 42), 32'd1);
    endtask

    task automatic clr_all();
        i_clr = '1;
        @(negedge clk);
        i_clr = '0;
    endtask

    initial begin
        int n, nr, nf;
        rst = 1'b1; i_sw = '0; i_clr = '0;
        cyc(2);
        chk("reset_sw", 32'(o_sw), 32'd0);
        chk("reset_irq", 32'(o_irq), 32'd0);
        rst = 1'b0;

        // 1: basic rise with latency window
        i_sw = 16'h0001;
        latency("rise_latency", 0);
        chk("rise_pulse", 32'(o_rise), 32'h1);
        chk("rise_irq", 32'(o_irq), 32'd1);
        cyc(1);
        chk("rise_one_cycle", 32'(o_rise), 32'h0);

        // 2: short glitch on bit 3
        i_sw[3] = 1'b1;
        cyc(25);
        i_sw[3] = 1'b0;
        cyc(60);
        chk("glitch_changed3", 32'(o_changed[3]), 32'd0);

        // 3: bounce on bit 5 then held high
        nr = 0; nf = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            nr += int'(o_rise[5]);
            nf += int'(o_fall[5]);
            i_sw[5] = (c < 60) ? (((c / 5) % 2) == 0) : 1'b1;
        end
        chk("bounce_rises", 32'(nr), 32'd1);
        chk("bounce_falls", 32'(nf), 32'd0);

        // 4: clear, then clear colliding with an accepted fall
        clr_all();
        @(negedge clk);
        chk("clr_changed", 32'(o_changed), 32'd0);
        chk("clr_irq", 32'(o_irq), 32'd0);
        i_sw[0] = 1'b0;
        i_clr[0] = 1'b1;
        n = 0;
        while (!o_fall[0] && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("collision_fall", 32'(o_fall[0]), 32'd1);
        chk("collision_set_wins", 32'(o_changed[0]), 32'd1);
        i_clr = '0;

        // 5: reset in the middle of a debounce run on bit 2
        i_sw = '0;
        cyc(50);
        clr_all();
        i_sw = 16'h0004;
        cyc(50);
        chk("pre_reset_changed", 32'(o_changed), 32'h4);
        i_sw = '0;
        n = 0;
        while (m_run[2] != 3 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("run_reached_3", 32'(m_run[2]), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_sw", 32'(o_sw), 32'd0);
        chk("midreset_changed", 32'(o_changed), 32'd0);
        i_sw = 16'h0004;
        latency("post_reset_latency", 2);

        // 6: all bits together
        i_sw = '0;
        cyc(50);
        clr_all();
        i_sw = 16'hFFFF;
        n = 0;
        while (o_rise == '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("wide_rise", 32'(o_rise), 32'hFFFF);
        chk("wide_sw", 32'(o_sw), 32'hFFFF);
        i_sw = 16'hA5A5;
        n = 0;
        while (o_fall == '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("wide_fall", 32'(o_fall), 32'h5A5A);
        chk("wide_fall_rise", 32'(o_rise), 32'h0);

        // random segments: bit flips, clears and occasional resets
        for (int s = 0; s < 40; s++) begin
            i_sw = i_sw ^ 16'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) i_clr = 16'($urandom);
            if ($urandom_range(0, 19) == 0) rst = 1'b1;
            @(negedge clk);
            i_clr = '0;
            rst = 1'b0;
            cyc($urandom_range(1, 50));
        end

        cyc(3);
        chk("scoreboard_drained", 32'(q.size() <= 1), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
